gpio_cmd_ctrl: RTL and testbench
================================

// Module: gpio_cmd_ctrl
// PURPOSE
//  Command controller between the MicroBlaze GPIO word and board I/O. Decodes strobe-framed
//  commands on gpo0 and drives a toggle request/ack handshake back on gpi0. Owns the RGB LED
//  pattern, mode and period registers, and runs a prescaled LED sequencer. Returns synchronised
//  switches and status. Sits in the top level between the micro and the LED/switch pins, clocked by clockdsp.
// PARAMETERS
//  NB_GPIOS        32          GPIO word width (in and out)
//  NB_SWITCHES     4           board switch count
//  NB_RGB          3           bits per RGB LED
//  N_RGB_LEDS      4           RGB LED count; pattern width NB_PAT = NB_RGB*N_RGB_LEDS = 12
//  NB_PERIOD       32          sequencer period register width (>16)
//  DEFAULT_PERIOD  50_000_000  period value loaded at reset
// PORTS
//  i_clk        in   1            single clock (clockdsp)
//  i_reset      in   1            asynchronous, active-low reset
//  i_gpo        in   NB_GPIOS     command word from micro: [31] strobe, [23:16] opcode, [15:0] data
//  i_sw         in   NB_SWITCHES  raw board switches (asynchronous)
//  o_gpi        out  NB_GPIOS     to micro: [31] ack, [30] err, [29:16] 0, [15:0] read data
//  o_leds_rgb   out  NB_PAT       RGB LED drive; LED k = bits [3k+2:3k]
//  o_seq_tick   out  1            one-cycle pulse per sequencer step (debug/VIO probe)
// BEHAVIOUR
//  Reset (async, i_reset=0): all outputs 0; pattern=0, mode=STATIC, run=0, period=DEFAULT_PERIOD,
//   shadow_lo=0, cnt=0. gpo_prev_strobe resets to 1, so a strobe held across reset is NOT executed.
//   The micro must drop the strobe and raise it again.
//  Input: i_gpo registered once (gpo_q). i_sw passes through a 2-FF synchroniser.
//   rise = gpo_q[31] & ~gpo_prev_strobe.
//  FSM IDLE -> EXEC -> ACK_WAIT -> IDLE:
//   IDLE: on rise, latch opcode and data from gpo_q -> EXEC.
//   EXEC: execute one cycle, update err and read data, set ack=1 -> ACK_WAIT.
//   ACK_WAIT: when gpo_q[31]==0, clear ack -> IDLE. err and read data hold until the next EXEC.
//  Latency: i_gpo[31] rises before edge k; o_gpi[31]=1 after edge k+2.
//   After the strobe drops, ack clears after 2 edges.
//  Payload must be stable while the strobe is high. It is sampled only on the IDLE->EXEC edge.
//  Opcodes (others: err=1, no state change):
//   0x00 NOP          err=0
//   0x01 WR_PATTERN   pattern = data[11:0]; cur = pattern; cnt = 0
//   0x02 WR_PERIOD_LO shadow_lo = data; period unchanged
//   0x03 WR_PERIOD_HI period = {data[NB_PERIOD-17:0], shadow_lo}; cnt = 0
//   0x04 WR_MODE      mode = data[1:0] (0 STATIC, 1 ROT_L, 2 ROT_R, 3 BLINK); run = data[2];
//                     cur = pattern; cnt = 0
//   0x05 RD_SW        rdata = zero-extended sync'd switches
//   0x06 RD_STATUS    rdata = {1'b0, run, mode[1:0], cur[11:0]}
//  Sequencer: when run=1 and mode!=STATIC, cnt counts 0..period, then wraps to 0 with tick=1
//   (one tick per period+1 cycles). period=0 gives a tick every cycle.
//   Otherwise cnt is held at 0 and cur = pattern.
//   On tick: ROT_L cur = {cur[8:0], cur[11:9]}; ROT_R cur = {cur[2:0], cur[11:3]};
//   BLINK cur = (cur==pattern) ? 0 : pattern. If pattern==0, BLINK stays 0.
//  A command update in EXEC on the same cycle as a tick wins: cur/cnt take command values and the tick is dropped.
//  o_leds_rgb = cur (registered). o_seq_tick is registered with cur.
// STRUCTURE
//  gpio_cmd_pkg.vh: opcode localparams, mode codes, GPIO field positions (STROBE_BIT=31,
//   OPC_MSB/LSB, DATA_MSB/LSB, ACK_BIT=31, ERR_BIT=30), FSM state encodings.
//  Sub-module led_sequencer: period counter plus pattern engine. Ports: clk, rst, load, pattern, mode,
//   run, period -> cur, tick. gpio_cmd_ctrl holds the synchroniser, FSM, registers and readback mux.
// TESTING
//  1 Reset with i_gpo=0 -> o_gpi=0, o_leds_rgb=0. Hold strobe=1 through reset release -> no ack
//    until the strobe toggles 0 then 1.
//  2 Cmd 0x01 data 0x0A5C -> ack after 3 edges; o_leds_rgb=0xA5C. Strobe low -> ack=0 2 edges later.
//  3 Cmds 0x02 0x0003, 0x03 0x0000, 0x04 0x0005 (ROT_L, run), pattern 0x007 -> o_leds_rgb
//    0x007 -> 0x038 -> 0x1C0 -> 0xE00 -> 0x007, one step every 4 cycles; tick pulses match.
//  4 BLINK with period 1, pattern 0xFFF -> 0xFFF/0x000 alternating every 2 cycles.
//    Cmd 0x04 data 0 -> holds 0xFFF.
//  5 i_sw=4'b1010, cmd 0x05 -> o_gpi[15:0]=0x000A, err=0. Opcode 0x7F -> err=1, registers unchanged.
//  6 Assert i_reset while in ACK_WAIT with ROT_L running -> all outputs 0 immediately;
//    period=DEFAULT_PERIOD after release.

Source files
------------

// File: rtl/gpio_cmd_ctrl_pkg.sv
// Shared definitions for the GPIO command controller: GPIO word fields,
// opcodes, LED sequencer modes and command FSM states.
package gpio_cmd_ctrl_pkg;

  localparam int STROBE_BIT = 31;
  localparam int OPC_MSB    = 23;
  localparam int OPC_LSB    = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;
  localparam int ACK_BIT    = 31;
  localparam int ERR_BIT    = 30;

  localparam int NB_OPC  = OPC_MSB - OPC_LSB + 1;
  localparam int NB_DATA = DATA_MSB - DATA_LSB + 1;

  localparam logic [NB_OPC-1:0] OP_NOP          = 8'h00;
  localparam logic [NB_OPC-1:0] OP_WR_PATTERN   = 8'h01;
  localparam logic [NB_OPC-1:0] OP_WR_PERIOD_LO = 8'h02;
  localparam logic [NB_OPC-1:0] OP_WR_PERIOD_HI = 8'h03;
  localparam logic [NB_OPC-1:0] OP_WR_MODE      = 8'h04;
  localparam logic [NB_OPC-1:0] OP_RD_SW        = 8'h05;
  localparam logic [NB_OPC-1:0] OP_RD_STATUS    = 8'h06;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROT_L  = 2'd1,
    MODE_ROT_R  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_ACK_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/gpio_cmd_ctrl_led_sequencer.sv
// Prescaled RGB LED pattern engine: a period counter that emits one tick per
// period+1 cycles and rotates or blinks the current pattern on each tick.
module led_sequencer
  import gpio_cmd_ctrl_pkg::*;
#(
  parameter int NB_RGB    = 3,
  parameter int NB_PAT    = 12,
  parameter int NB_PERIOD = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 restart,
  input  logic [NB_PAT-1:0]    pattern,
  input  mode_e                mode,
  input  logic                 run,
  input  logic [NB_PERIOD-1:0] period,
  output logic [NB_PAT-1:0]    cur,
  output logic                 tick
);

  logic [NB_PERIOD-1:0] cnt;
  logic                 active;
  logic                 wrap;
  logic [NB_PAT-1:0]    cur_step;

  assign active = run && (mode != MODE_STATIC);
  // >= rather than == keeps the counter bounded even if period shrinks mid-count.
  assign wrap   = active && (cnt >= period);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cur_step = cur;
    case (mode)
      MODE_ROT_L: cur_step = {cur[NB_PAT-NB_RGB-1:0], cur[NB_PAT-1:NB_PAT-NB_RGB]};
      MODE_ROT_R: cur_step = {cur[NB_RGB-1:0], cur[NB_PAT-1:NB_RGB]};
      MODE_BLINK: cur_step = (cur == pattern) ? '0 : pattern;
      default:    cur_step = cur;
    endcase
  end

  // Command updates take priority over a coincident tick, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      cur  <= '0;
      tick <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      cur  <= pattern;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      cur  <= active ? cur : pattern;
      tick <= 1'b0;
    end else if (!active) begin
      cnt  <= '0;
      cur  <= pattern;
      tick <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      cur  <= cur_step;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// Command controller between the MicroBlaze GPIO word and the board LEDs and
// switches: strobe/ack command FSM, LED registers, switch synchroniser, readback.
module gpio_cmd_ctrl
  import gpio_cmd_ctrl_pkg::*;
#(
  parameter int NB_GPIOS       = 32,
  parameter int NB_SWITCHES    = 4,
  parameter int NB_RGB         = 3,
  parameter int N_RGB_LEDS     = 4,
  parameter int NB_PAT         = NB_RGB * N_RGB_LEDS,
  parameter int NB_PERIOD      = 32,
  parameter int DEFAULT_PERIOD = 50_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_GPIOS-1:0]    i_gpo,
  input  logic [NB_SWITCHES-1:0] i_sw,
  output logic [NB_GPIOS-1:0]    o_gpi,
  output logic [NB_PAT-1:0]      o_leds_rgb,
  output logic                   o_seq_tick
);

  // Strobe bit resets high so a strobe held across reset does not look like a new edge.
  localparam logic [NB_GPIOS-1:0] GPO_RESET = NB_GPIOS'(1) << STROBE_BIT;

  logic [NB_GPIOS-1:0]    gpo_q;
  logic                   gpo_prev_strobe;
  logic                   rise;
  logic [NB_SWITCHES-1:0] sw_meta;
  logic [NB_SWITCHES-1:0] sw_sync;

  state_e                 state_q, state_d;
  logic [NB_OPC-1:0]      opc_q;
  logic [NB_DATA-1:0]     data_q;

  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [NB_DATA-1:0]     rdata_q, rdata_d;
  logic [NB_PAT-1:0]      pattern_q, pattern_d;
  mode_e                  mode_q, mode_d;
  logic                   run_q, run_d;
  logic [NB_PERIOD-1:0]   period_q, period_d;
  logic [NB_DATA-1:0]     shadow_lo_q, shadow_lo_d;
  logic                   seq_load, seq_restart;
  logic [NB_PAT-1:0]      cur;

  assign rise = gpo_q[STROBE_BIT] & ~gpo_prev_strobe;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      gpo_q           <= GPO_RESET;
      gpo_prev_strobe <= 1'b1;
      sw_meta         <= '0;
      sw_sync         <= '0;
    end else begin
      gpo_q           <= i_gpo;
      gpo_prev_strobe <= gpo_q[STROBE_BIT];
      sw_meta         <= i_sw;
      sw_sync         <= sw_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rise) state_d = ST_EXEC;
      ST_EXEC:     state_d = ST_ACK_WAIT;
      ST_ACK_WAIT: if (!gpo_q[STROBE_BIT]) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d       = ack_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    pattern_d   = pattern_q;
    mode_d      = mode_q;
    run_d       = run_q;
    period_d    = period_q;
    shadow_lo_d = shadow_lo_q;
    seq_load    = 1'b0;
    seq_restart = 1'b0;
    case (state_q)
      ST_EXEC: begin
        ack_d   = 1'b1;
        err_d   = 1'b0;
        rdata_d = '0;
        case (opc_q)
          OP_NOP: ;
          OP_WR_PATTERN: begin
            pattern_d = data_q[NB_PAT-1:0];
            seq_load  = 1'b1;
          end
          OP_WR_PERIOD_LO: shadow_lo_d = data_q;
          OP_WR_PERIOD_HI: begin
            period_d    = {data_q[NB_PERIOD-17:0], shadow_lo_q};
            seq_restart = 1'b1;
          end
          OP_WR_MODE: begin
            mode_d   = mode_e'(data_q[1:0]);
            run_d    = data_q[2];
            seq_load = 1'b1;
          end
          OP_RD_SW:     rdata_d = NB_DATA'(sw_sync);
          OP_RD_STATUS: rdata_d = {1'b0, run_q, mode_q, 12'(cur)};
          default:      err_d = 1'b1;
        endcase
      end
      ST_ACK_WAIT: if (!gpo_q[STROBE_BIT]) ack_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      opc_q       <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      pattern_q   <= '0;
      mode_q      <= MODE_STATIC;
      run_q       <= 1'b0;
      period_q    <= NB_PERIOD'(DEFAULT_PERIOD);
      shadow_lo_q <= '0;
    end else begin
      if (state_q == ST_IDLE && rise) begin
        opc_q  <= gpo_q[OPC_MSB:OPC_LSB];
        data_q <= gpo_q[DATA_MSB:DATA_LSB];
      end
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      pattern_q   <= pattern_d;
      mode_q      <= mode_d;
      run_q       <= run_d;
      period_q    <= period_d;
      shadow_lo_q <= shadow_lo_d;
    end
  end

  // The sequencer sees next-state register values so a write takes effect on its own EXEC edge.
  led_sequencer #(
    .NB_RGB   (NB_RGB),
    .NB_PAT   (NB_PAT),
    .NB_PERIOD(NB_PERIOD)
  ) u_led_sequencer (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .load   (seq_load),
    .restart(seq_restart),
    .pattern(pattern_d),
    .mode   (mode_d),
    .run    (run_d),
    .period (period_d),
    .cur    (cur),
    .tick   (o_seq_tick)
  );

  assign o_leds_rgb = cur;

  always_comb begin
    o_gpi                    = '0;
    o_gpi[ACK_BIT]           = ack_q;
    o_gpi[ERR_BIT]           = err_q;
    o_gpi[DATA_MSB:DATA_LSB] = rdata_q;
  end

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Directed self-checking bench for gpio_cmd_ctrl: command handshake, LED
// sequencer modes, switch readback, illegal opcodes and reset behaviour.
module tb_gpio_cmd_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_gpo;
  logic [3:0]  i_sw;
  logic [31:0] o_gpi;
  logic [11:0] o_leds_rgb;
  logic        o_seq_tick;

  int vectors;
  int miscompares;

  gpio_cmd_ctrl #(
    .DEFAULT_PERIOD(5)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_gpo     (i_gpo),
    .i_sw      (i_sw),
    .o_gpi     (o_gpi),
    .o_leds_rgb(o_leds_rgb),
    .o_seq_tick(o_seq_tick)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] data);
    i_gpo = {1'b1, 7'b0, op, data};
    cyc(3);
    check("cmd_ack", {31'b0, o_gpi[31]}, 32'd1);
    i_gpo[31] = 1'b0;
    cyc(2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset     = 1'b0;
    i_gpo       = '0;
    i_sw        = '0;

    // 1: reset state, then a strobe held through reset release is ignored
    cyc(3);
    check("rst_gpi",  o_gpi, 32'h0);
    check("rst_leds", {20'b0, o_leds_rgb}, 32'h0);
    check("rst_tick", {31'b0, o_seq_tick}, 32'h0);
    i_reset = 1'b1;
    cyc(2);
    i_reset = 1'b0;
    i_gpo   = {1'b1, 7'b0, 8'h01, 16'h0123};
    cyc(2);
    i_reset = 1'b1;
    cyc(6);
    check("held_strobe_no_ack",  o_gpi, 32'h0);
    check("held_strobe_no_leds", {20'b0, o_leds_rgb}, 32'h0);
    i_gpo[31] = 1'b0;
    cyc(2);

    // 2: WR_PATTERN latency and ack release
    i_gpo = {1'b1, 7'b0, 8'h01, 16'h0A5C};
    cyc(2);
    check("ack_not_yet", {31'b0, o_gpi[31]}, 32'd0);
    cyc(1);
    check("ack_edge3", o_gpi, 32'h8000_0000);
    check("pattern_a5c", {20'b0, o_leds_rgb}, 32'h0000_0A5C);
    i_gpo[31] = 1'b0;
    cyc(1);
    check("ack_hold", {31'b0, o_gpi[31]}, 32'd1);
    cyc(1);
    check("ack_clear", {31'b0, o_gpi[31]}, 32'd0);

    // 3: ROT_L, period 3 -> one step every 4 cycles
    send_cmd(8'h02, 16'h0003);
    send_cmd(8'h03, 16'h0000);
    send_cmd(8'h01, 16'h0007);
    check("static_after_pat", {20'b0, o_leds_rgb}, 32'h007);
    send_cmd(8'h04, 16'h0005);
    check("rotl_start", {20'b0, o_leds_rgb}, 32'h007);
    cyc(1);
    check("rotl_c3_leds", {20'b0, o_leds_rgb}, 32'h007);
    check("rotl_c3_tick", {31'b0, o_seq_tick}, 32'd0);
    cyc(1);
    check("rotl_s1_leds", {20'b0, o_leds_rgb}, 32'h038);
    check("rotl_s1_tick", {31'b0, o_seq_tick}, 32'd1);
    cyc(1);
    check("rotl_tick_pulse", {31'b0, o_seq_tick}, 32'd0);
    cyc(3);
    check("rotl_s2_leds", {20'b0, o_leds_rgb}, 32'h1C0);
    check("rotl_s2_tick", {31'b0, o_seq_tick}, 32'd1);
    cyc(4);
    check("rotl_s3_leds", {20'b0, o_leds_rgb}, 32'hE00);
    cyc(4);
    check("rotl_wrap_leds", {20'b0, o_leds_rgb}, 32'h007);

    // 4: BLINK, period 1, pattern 0xFFF, then back to STATIC
    send_cmd(8'h02, 16'h0001);
    send_cmd(8'h03, 16'h0000);
    send_cmd(8'h01, 16'h0FFF);
    send_cmd(8'h04, 16'h0007);
    check("blink_off1", {20'b0, o_leds_rgb}, 32'h000);
    check("blink_off1_tick", {31'b0, o_seq_tick}, 32'd1);
    cyc(1);
    check("blink_off1_hold", {20'b0, o_leds_rgb}, 32'h000);
    cyc(1);
    check("blink_on", {20'b0, o_leds_rgb}, 32'hFFF);
    cyc(2);
    check("blink_off2", {20'b0, o_leds_rgb}, 32'h000);
    send_cmd(8'h04, 16'h0000);
    check("static_fff", {20'b0, o_leds_rgb}, 32'hFFF);
    cyc(5);
    check("static_hold", {20'b0, o_leds_rgb}, 32'hFFF);
    check("static_no_tick", {31'b0, o_seq_tick}, 32'd0);

    // 5: switch readback, status readback, illegal opcode
    i_sw = 4'b1010;
    send_cmd(8'h05, 16'h0000);
    check("rd_sw", o_gpi, 32'h0000_000A);
    send_cmd(8'h06, 16'h0000);
    check("rd_status", o_gpi, 32'h0000_0FFF);
    send_cmd(8'h7F, 16'h0123);
    check("bad_op_err", {31'b0, o_gpi[30]}, 32'd1);
    check("bad_op_leds", {20'b0, o_leds_rgb}, 32'hFFF);
    send_cmd(8'h06, 16'h0000);
    check("rd_status_after_bad", o_gpi, 32'h0000_0FFF);

    // 6: reset during ACK_WAIT with ROT_L running
    send_cmd(8'h02, 16'h0003);
    send_cmd(8'h03, 16'h0000);
    send_cmd(8'h01, 16'h0007);
    send_cmd(8'h04, 16'h0005);
    i_gpo = {1'b1, 7'b0, 8'h00, 16'h0000};
    cyc(3);
    check("nop_ack", o_gpi, 32'h8000_0000);
    check("leds_before_rst", {31'b0, (o_leds_rgb != 12'h000)}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("async_rst_gpi",  o_gpi, 32'h0);
    check("async_rst_leds", {20'b0, o_leds_rgb}, 32'h0);
    check("async_rst_tick", {31'b0, o_seq_tick}, 32'h0);
    i_gpo = '0;
    cyc(2);
    i_reset = 1'b1;
    cyc(1);
    send_cmd(8'h01, 16'h0007);
    send_cmd(8'h04, 16'h0005);
    cyc(3);
    check("dflt_period_hold", {20'b0, o_leds_rgb}, 32'h007);
    check("dflt_period_no_tick", {31'b0, o_seq_tick}, 32'd0);
    cyc(1);
    check("dflt_period_step", {20'b0, o_leds_rgb}, 32'h038);
    check("dflt_period_tick", {31'b0, o_seq_tick}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
